// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level request latching, per-source mask, fixed-priority
// request/ack/EOI sequencing to CP0. Optional per-source event counters under IRQ_CNT_EN.
module irq_ctrl #(
  parameter int NSRC  = 3,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic [4:0]      pr_a,
  input  logic            pr_we,
  input  logic [31:0]     pr_wd,
  output logic [31:0]     pr_rd,
  output logic [5:0]      hw_int,
  output logic            int_req,
  output logic [2:0]      int_id,
  input  logic            int_ack,
  input  logic            eoi
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]      state;
  logic [NSRC-1:0] pend, mask, mode, irq_d;
  logic [NSRC-1:0] active, edge_det, w1c, ack_clr, pend_nxt, id_dec, hw_mask;
  logic [2:0]      sel_id;
  logic            drop, take_ack;
  logic            unused_wd;

  assign unused_wd = ^pr_wd[31:NSRC];

  assign active   = pend & mask;
  assign edge_det = irq & ~irq_d;
  assign w1c      = (pr_we && pr_a == 5'd0) ? pr_wd[NSRC-1:0] : '0;
  assign drop     = (state == REQ) && ((active & id_dec) == '0);
  assign take_ack = (state == REQ) && !drop && int_ack;
  assign ack_clr  = take_ack ? (id_dec & mode) : '0;
  // A fresh edge always wins over W1C or the acknowledge clear of the same cycle
  assign pend_nxt = (mode & (edge_det | (pend & ~(w1c | ack_clr)))) | (~mode & irq);
  assign int_req  = (state == REQ);

  always_comb begin
    sel_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) sel_id = 3'(i);
    end
  end

  // While servicing, only strictly higher-priority sources reach CP0
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      id_dec[i]  = (int_id == 3'(i));
      hw_mask[i] = (state != SERVICE) || (3'(i) < int_id);
    end
  end

  always_comb begin
    hw_int = '0;
    hw_int[NSRC-1:0] = active & hw_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend  <= '0;
      mask  <= '0;
      mode  <= '1;
      irq_d <= '0;
    end else begin
      irq_d <= irq;
      pend  <= pend_nxt;
      if (pr_we && pr_a == 5'd1) mask <= pr_wd[NSRC-1:0];
      if (pr_we && pr_a == 5'd2) mode <= pr_wd[NSRC-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      int_id <= '0;
    end else begin
      case (state)
        IDLE: if (active != '0) begin
          int_id <= sel_id;
          state  <= REQ;
        end
        REQ: begin
          if (drop)         state <= IDLE;
          else if (int_ack) state <= SERVICE;
        end
        SERVICE: if (eoi) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IRQ_CNT_EN
  logic [CNT_W-1:0] cnt [NSRC];
  logic [NSRC-1:0]  cnt_evt;

  assign cnt_evt = (mode & edge_det) | (~mode & irq & ~pend);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (pr_we && pr_a == 5'(4 + i))
          cnt[i] <= cnt_evt[i] ? CNT_W'(1) : '0;
        else if (cnt_evt[i] && !(&cnt[i]))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

  always_comb begin
    pr_rd = '0;
    case (pr_a)
      5'd0: pr_rd[NSRC-1:0] = pend;
      5'd1: pr_rd[NSRC-1:0] = mask;
      5'd2: pr_rd[NSRC-1:0] = mode;
      5'd3: pr_rd = {27'b0, state, int_id};
      default: pr_rd = '0;
    endcase
`ifdef IRQ_CNT_EN
    for (int i = 0; i < NSRC; i++) begin
      if (pr_a == 5'(4 + i)) pr_rd = 32'(cnt[i]);
    end
`endif
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register map, priority sequencing, hw_int masking, W1C races.
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  irq;
  logic [4:0]  pr_a;
  logic        pr_we;
  logic [31:0] pr_wd;
  logic [31:0] pr_rd;
  logic [5:0]  hw_int;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack;
  logic        eoi;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] d;

  irq_ctrl #(.NSRC(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .irq(irq), .pr_a(pr_a), .pr_we(pr_we), .pr_wd(pr_wd),
    .pr_rd(pr_rd), .hw_int(hw_int), .int_req(int_req), .int_id(int_id),
    .int_ack(int_ack), .eoi(eoi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    pr_a = a; pr_wd = v; pr_we = 1'b1;
    tick();
    pr_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    pr_a = a;
    #1;
    v = pr_rd;
  endtask

  task automatic pulse_irq(input logic [2:0] v);
    irq = v;
    tick();
    irq = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq = '0; pr_a = '0; pr_we = 1'b0; pr_wd = '0; int_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    total_cnt++; if (hw_int !== 6'b0) $display("FAIL reset_hw_int got %b exp %b", hw_int, 6'b0); else pass_cnt++;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL reset_int_req got %b exp 0", int_req); else pass_cnt++;
    rd(5'd2, d);
    total_cnt++; if (d !== 32'h7) $display("FAIL reset_mode got %h exp %h", d, 32'h7); else pass_cnt++;
    rd(5'd1, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL reset_mask got %h exp %h", d, 32'h0); else pass_cnt++;
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL reset_status got %h exp %h", d, 32'h0); else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    wr(5'd1, 32'h7);
    pulse_irq(3'b010);
    rd(5'd0, d);
    total_cnt++; if (d !== 32'h2) $display("FAIL basic_pend got %h exp %h", d, 32'h2); else pass_cnt++;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL basic_req_early got %b exp 0", int_req); else pass_cnt++;
    total_cnt++; if (hw_int !== 6'b000010) $display("FAIL basic_hw_int got %b exp %b", hw_int, 6'b000010); else pass_cnt++;
    tick();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL basic_req got %b exp 1", int_req); else pass_cnt++;
    total_cnt++; if (int_id !== 3'd1) $display("FAIL basic_id got %0d exp 1", int_id); else pass_cnt++;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h11) $display("FAIL basic_status_svc got %h exp %h", d, 32'h11); else pass_cnt++;
    rd(5'd0, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL basic_pend_ackclr got %h exp %h", d, 32'h0); else pass_cnt++;
    eoi = 1'b1; tick(); eoi = 1'b0;
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h1) $display("FAIL basic_status_idle got %h exp %h", d, 32'h1); else pass_cnt++;
  endtask

  task automatic test_priority();
    pulse_irq(3'b101);
    tick();
    total_cnt++; if (int_id !== 3'd0 || int_req !== 1'b1) $display("FAIL prio_first got id=%0d req=%b exp id=0 req=1", int_id, int_req); else pass_cnt++;
    total_cnt++; if (hw_int !== 6'b000101) $display("FAIL prio_hw_int got %b exp %b", hw_int, 6'b000101); else pass_cnt++;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    total_cnt++; if (hw_int !== 6'b0) $display("FAIL prio_svc0_hw got %b exp %b", hw_int, 6'b0); else pass_cnt++;
    eoi = 1'b1; tick(); eoi = 1'b0;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL prio_eoi_idle got %b exp 0", int_req); else pass_cnt++;
    tick();
    total_cnt++; if (int_id !== 3'd2 || int_req !== 1'b1) $display("FAIL prio_second got id=%0d req=%b exp id=2 req=1", int_id, int_req); else pass_cnt++;
  endtask

  task automatic test_service_mask();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    pulse_irq(3'b001);
    total_cnt++; if (hw_int !== 6'b000001) $display("FAIL svc2_higher got %b exp %b", hw_int, 6'b000001); else pass_cnt++;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL svc2_req got %b exp 0", int_req); else pass_cnt++;
    wr(5'd0, 32'h1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    pulse_irq(3'b010);
    tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    pulse_irq(3'b100);
    total_cnt++; if (hw_int !== 6'b0) $display("FAIL svc1_lower got %b exp %b", hw_int, 6'b0); else pass_cnt++;
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h11) $display("FAIL svc1_status got %h exp %h", d, 32'h11); else pass_cnt++;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    rd(5'd0, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL svc_clean_pend got %h exp %h", d, 32'h0); else pass_cnt++;
  endtask

  task automatic test_level();
    wr(5'd2, 32'h3);
    irq = 3'b100;
    tick(); tick();
    total_cnt++; if (int_id !== 3'd2 || int_req !== 1'b1) $display("FAIL lvl_req got id=%0d req=%b exp id=2 req=1", int_id, int_req); else pass_cnt++;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    total_cnt++; if (int_id !== 3'd2 || int_req !== 1'b1) $display("FAIL lvl_rereq got id=%0d req=%b exp id=2 req=1", int_id, int_req); else pass_cnt++;
    irq = 3'b000;
    tick(); tick();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL lvl_drop_req got %b exp 0", int_req); else pass_cnt++;
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h2) $display("FAIL lvl_drop_status got %h exp %h", d, 32'h2); else pass_cnt++;
    wr(5'd2, 32'h7);
  endtask

  task automatic test_w1c_race();
    wr(5'd1, 32'h0);
    pulse_irq(3'b001);
    tick();
    pr_a = 5'd0; pr_wd = 32'h1; pr_we = 1'b1; irq = 3'b001;
    tick();
    pr_we = 1'b0; irq = 3'b000;
    rd(5'd0, d);
    total_cnt++; if (d !== 32'h1) $display("FAIL w1c_race got %h exp %h", d, 32'h1); else pass_cnt++;
    wr(5'd0, 32'h1);
    rd(5'd0, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL w1c_plain got %h exp %h", d, 32'h0); else pass_cnt++;
    wr(5'd1, 32'h7);
    pulse_irq(3'b001);
    tick();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL mask_req got %b exp 1", int_req); else pass_cnt++;
    wr(5'd1, 32'h6);
    total_cnt++; if (hw_int !== 6'b0) $display("FAIL mask_hw_int got %b exp %b", hw_int, 6'b0); else pass_cnt++;
    tick();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL mask_drop_req got %b exp 0", int_req); else pass_cnt++;
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL mask_drop_status got %h exp %h", d, 32'h0); else pass_cnt++;
    wr(5'd0, 32'h1);
  endtask

  task automatic test_misc();
    int_ack = 1'b1; eoi = 1'b1; tick(); int_ack = 1'b0; eoi = 1'b0;
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL stray_ack_eoi got %h exp %h", d, 32'h0); else pass_cnt++;
    wr(5'd10, 32'hFFFF_FFFF);
    rd(5'd10, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL unmapped got %h exp %h", d, 32'h0); else pass_cnt++;
    wr(5'd1, 32'hFFFF_FFFF);
    rd(5'd1, d);
    total_cnt++; if (d !== 32'h7) $display("FAIL mask_width got %h exp %h", d, 32'h7); else pass_cnt++;
  endtask

  task automatic test_counter();
    wr(5'd1, 32'h0);
    wr(5'd4, 32'h0);
`ifdef IRQ_CNT_EN
    for (int i = 0; i < 300; i++) begin
      pulse_irq(3'b001);
      tick();
    end
    rd(5'd4, d);
    total_cnt++; if (d !== 32'hFF) $display("FAIL cnt_sat got %h exp %h", d, 32'hFF); else pass_cnt++;
    wr(5'd4, 32'h0);
    rd(5'd4, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL cnt_clr got %h exp %h", d, 32'h0); else pass_cnt++;
    pr_a = 5'd4; pr_wd = 32'h0; pr_we = 1'b1; irq = 3'b001;
    tick();
    pr_we = 1'b0; irq = 3'b000;
    rd(5'd4, d);
    total_cnt++; if (d !== 32'h1) $display("FAIL cnt_clr_race got %h exp %h", d, 32'h1); else pass_cnt++;
`else
    pulse_irq(3'b001);
    rd(5'd4, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL cnt_absent got %h exp %h", d, 32'h0); else pass_cnt++;
`endif
    wr(5'd0, 32'h7);
  endtask

  task automatic test_reset_mid();
    wr(5'd1, 32'h7);
    pulse_irq(3'b010);
    tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    pulse_irq(3'b001);
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h11) $display("FAIL mid_status_svc got %h exp %h", d, 32'h11); else pass_cnt++;
    reset = 1'b1;
    #1;
    rd(5'd3, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL mid_reset_status got %h exp %h", d, 32'h0); else pass_cnt++;
    total_cnt++; if (hw_int !== 6'b0 || int_req !== 1'b0) $display("FAIL mid_reset_out got hw=%b req=%b exp hw=0 req=0", hw_int, int_req); else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_service_mask();
    test_level();
    test_w1c_race();
    test_misc();
    test_counter();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
